// File: rtl/gate_id_pkg.sv
// Shared types and constants for the gate identifier: FSM states,
// gate classification codes and the truth patterns that map onto them.
package gate_id_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_t;

  localparam logic [2:0] GC_NOT     = 3'd0;
  localparam logic [2:0] GC_OR      = 3'd1;
  localparam logic [2:0] GC_AND     = 3'd2;
  localparam logic [2:0] GC_NAND    = 3'd3;
  localparam logic [2:0] GC_NOR     = 3'd4;
  localparam logic [2:0] GC_XOR     = 3'd5;
  localparam logic [2:0] GC_XNOR    = 3'd6;
  localparam logic [2:0] GC_UNKNOWN = 3'd7;

  // Bit index of each pattern is {a,b}.
  localparam logic [3:0] TT_NOT  = 4'b0101;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_classifier.sv
// Combinational map from a captured 2-input truth table to a gate code
// plus a valid flag (low for any pattern that is not a known gate).
module gate_classifier
  import gate_id_pkg::*;
(
  input  logic [3:0] i_truth,
  output logic [2:0] o_code,
  output logic       o_valid
);

  always_comb begin
    o_code = GC_UNKNOWN;
    case (i_truth)
      TT_NOT:  o_code = GC_NOT;
      TT_OR:   o_code = GC_OR;
      TT_AND:  o_code = GC_AND;
      TT_NAND: o_code = GC_NAND;
      TT_NOR:  o_code = GC_NOR;
      TT_XOR:  o_code = GC_XOR;
      TT_XNOR: o_code = GC_XNOR;
      default: o_code = GC_UNKNOWN;
    endcase
    o_valid = (o_code != GC_UNKNOWN);
  end

endmodule

// File: rtl/gate_identifier.sv
// Steps an unknown 2-input gate through all four input combinations,
// captures its truth table and classifies it.
module gate_identifier
  import gate_id_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       sample,
  output logic       drive_a,
  output logic       drive_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth,
  output logic [2:0] gate_code,
  output logic       gate_valid
);

  localparam int unsigned   CW       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  state_t        r_state;
  logic [1:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_shadow;
  logic [2:0]    w_code;
  logic          w_valid;

  gate_classifier u_classifier (
    .i_truth (r_shadow),
    .o_code  (w_code),
    .o_valid (w_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_shadow   <= '0;
      drive_a    <= 1'b0;
      drive_b    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      truth      <= '0;
      gate_code  <= GC_UNKNOWN;
      gate_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          drive_a <= 1'b0;
          drive_b <= 1'b0;
          if (start) begin
            r_idx    <= '0;
            r_cnt    <= '0;
            r_shadow <= '0;
            busy     <= 1'b1;
            r_state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_cnt == CNT_LAST) begin
            r_shadow[r_idx] <= sample;
            r_cnt           <= '0;
            if (r_idx == 2'd3) begin
              drive_a <= 1'b0;
              drive_b <= 1'b0;
              r_state <= DONE;
            end else begin
              r_idx              <= r_idx + 2'd1;
              {drive_a, drive_b} <= r_idx + 2'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          done       <= 1'b1;
          busy       <= 1'b0;
          truth      <= r_shadow;
          gate_code  <= w_code;
          gate_valid <= w_valid;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
